// File: rtl/encoder_position_tracker.sv
// encoder_position_tracker: saturating encoder position, press classification and CPU event flags (ENC_ACCEL_EN enables fast-step acceleration)
module encoder_position_tracker #(
  parameter int TICK_DIV  = 100000,
  parameter int POS_MIN   = 0,
  parameter int POS_MAX   = 255,
  parameter int FAST_MS   = 20,
  parameter int STEP_FAST = 4,
  parameter int LONG_MS   = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_state_change_stb,
  input  logic        click,
  input  logic        clockwise,
  input  logic        switch,
  input  logic        pos_rd_stb,
  input  logic        pos_wr_stb,
  input  logic [15:0] pos_wr_data,
  output logic [15:0] position,
  output logic [7:0]  event_reg,
  output logic        irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {SW_IDLE, SW_PRESSED, SW_LONG} sw_state_e;
  sw_state_e   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]  hold_q, hold_d;
  logic        sw_q, sw_d;
  logic [5:0]  flags_q, flags_d;
  logic [15:0] position_q, position_d;
  logic [7:0]  ev_q, ev_d;
  logic        irq_q, irq_d;
  logic        tick, detent, clip, rise, rel, set_short, set_long;
  logic [16:0] step, up;
  logic [15:0] dn, next_pos, wr_clamp;
`ifdef ENC_ACCEL_EN
  logic [7:0]  ivl_q, ivl_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{FAST_MS[0], STEP_FAST[0]};
`endif
  assign position  = position_q;
  assign event_reg = ev_q;
  assign irq       = irq_q;
  // ms prescaler, step size and saturating position arithmetic at 17 bits
  always_comb begin
    tick    = presc_q == PW'(TICK_DIV - 1);
    presc_d = tick ? '0 : presc_q + PW'(1);
    detent  = enc_state_change_stb && click && !pos_wr_stb;
`ifdef ENC_ACCEL_EN
    step  = (32'(ivl_q) < FAST_MS) ? 17'(STEP_FAST) : 17'd1;
    ivl_d = detent ? 8'd0 : (tick && ivl_q != 8'hff) ? ivl_q + 8'd1 : ivl_q;
`else
    step  = 17'd1;
`endif
    up       = {1'b0, position_q} + step;
    dn       = position_q - step[15:0];
    clip     = clockwise ? (up > 17'(POS_MAX)) : ({1'b0, position_q} < 17'(POS_MIN) + step);
    next_pos = clockwise ? (clip ? 16'(POS_MAX) : up[15:0]) : (clip ? 16'(POS_MIN) : dn);
    wr_clamp = pos_wr_data > 16'(POS_MAX) ? 16'(POS_MAX) :
               pos_wr_data < 16'(POS_MIN) ? 16'(POS_MIN) : pos_wr_data;
    position_d = pos_wr_stb ? wr_clamp : detent ? next_pos : position_q;
  end
  // switch latch and press classifier; hold only advances while pressed
  always_comb begin
    sw_d      = enc_state_change_stb ? switch : sw_q;
    rise      = enc_state_change_stb && switch && !sw_q;
    rel       = enc_state_change_stb && !switch;
    state_d   = state_q;
    hold_d    = hold_q;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      SW_IDLE: if (rise) begin
        state_d = SW_PRESSED;
        hold_d  = '0;
      end
      SW_PRESSED: if (32'(hold_q) >= LONG_MS) begin
        set_long = 1'b1;
        state_d  = rel ? SW_IDLE : SW_LONG;
      end else if (rel) begin
        set_short = 1'b1;
        state_d   = SW_IDLE;
      end else if (tick && hold_q != 10'h3ff) hold_d = hold_q + 10'd1;
      SW_LONG: if (rel) state_d = SW_IDLE;
      default: state_d = SW_IDLE;
    endcase
  end
  // sticky flags: set wins over read-clear, DIR just tracks the last detent
  always_comb begin
    flags_d    = (flags_q & ~(pos_rd_stb ? 6'b111101 : 6'b0)) |
                 {detent && flags_q[0], detent && clip, set_long, set_short, 1'b0, detent};
    flags_d[1] = detent ? clockwise : flags_q[1];
    ev_d       = pos_rd_stb ? {2'b00, flags_q} : ev_q;
    irq_d      = |flags_q[3:0];
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hold_q     <= '0;
      state_q    <= SW_IDLE;
      sw_q       <= 1'b0;
      flags_q    <= '0;
      position_q <= 16'(POS_MIN);
      ev_q       <= '0;
      irq_q      <= 1'b0;
`ifdef ENC_ACCEL_EN
      ivl_q      <= 8'hff;
`endif
    end else begin
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      sw_q       <= sw_d;
      flags_q    <= flags_d;
      position_q <= position_d;
      ev_q       <= ev_d;
      irq_q      <= irq_d;
`ifdef ENC_ACCEL_EN
      ivl_q      <= ivl_d;
`endif
    end
  end
endmodule

// File: tb/tb_encoder_position_tracker.sv
// tb_encoder_position_tracker: scoreboard bench, every CPU read pushes expected position/event_reg/irq
module tb_encoder_position_tracker;
  localparam int TD = 10;
`ifdef ENC_ACCEL_EN
  localparam logic [15:0] A2 = 16'd105, A3 = 16'd109;
`else
  localparam logic [15:0] A2 = 16'd102, A3 = 16'd103;
`endif
  logic clk = 0, reset = 1, stb = 0, click = 0, clockwise = 0, switch = 0;
  logic pos_rd_stb = 0, pos_wr_stb = 0, rd_seen = 0, sw_lvl = 0;
  logic [15:0] pos_wr_data = 0, position;
  logic [7:0] event_reg;
  logic irq;
  int n_cmp = 0, n_bad = 0;
  typedef struct { string nm; logic [15:0] p; logic [7:0] e; logic i; } exp_t;
  exp_t q[$];
  encoder_position_tracker #(.TICK_DIV(TD)) u_dut (
    .clk(clk), .reset(reset), .enc_state_change_stb(stb), .click(click),
    .clockwise(clockwise), .switch(switch), .pos_rd_stb(pos_rd_stb),
    .pos_wr_stb(pos_wr_stb), .pos_wr_data(pos_wr_data),
    .position(position), .event_reg(event_reg), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_seen <= pos_rd_stb;
  task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, f, act, exp);
    end
  endtask
  always @(negedge clk) if (rd_seen) begin
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_read: got read with empty scoreboard expected none");
    end else begin
      exp_t x;
      x = q.pop_front();
      chk(x.nm, "position", position, x.p);
      chk(x.nm, "event_reg", {8'h00, event_reg}, {8'h00, x.e});
      chk(x.nm, "irq", {15'd0, irq}, {15'd0, x.i});
    end
  end
  task automatic drive(input logic s, c, cw, sw, r, w, input logic [15:0] wd);
    @(negedge clk);
    stb = s; click = c; clockwise = cw; switch = sw;
    pos_rd_stb = r; pos_wr_stb = w; pos_wr_data = wd;
    @(negedge clk);
    stb = 0; click = 0; clockwise = 0; switch = 0;
    pos_rd_stb = 0; pos_wr_stb = 0; pos_wr_data = 0;
  endtask
  task automatic det(input logic cw);
    drive(1, 1, cw, sw_lvl, 0, 0, 16'd0);
  endtask
  task automatic rd(input logic [15:0] p, input logic [7:0] e, input logic i, input string nm);
    q.push_back('{nm, p, e, i});
    drive(0, 0, 0, 0, 1, 0, 16'd0);
  endtask
  task automatic wr(input logic [15:0] d);
    drive(0, 0, 0, 0, 0, 1, d);
  endtask
  task automatic sw(input logic l);
    sw_lvl = l;
    drive(1, 0, 0, l, 0, 0, 16'd0);
  endtask
  task automatic ms(input int n);
    repeat (n * TD) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    rd(16'd0, 8'h00, 0, "reset");
    for (int k = 1; k <= 3; k++) begin
      ms(50);
      det(1);
      rd(16'(k), 8'h03, 1, "slow");
    end
    rd(16'd3, 8'h02, 1, "slow_dir_kept");
    wr(16'd100);
    ms(30);
    det(1);
    rd(16'd101, 8'h03, 1, "accel1");
    ms(5);
    det(1);
    rd(A2, 8'h03, 1, "accel2");
    ms(5);
    det(1);
    rd(A3, 8'h03, 1, "accel3");
    wr(16'd254);
    det(1);
    det(1);
    rd(16'd255, 8'h33, 1, "sat_hi");
    wr(16'd0);
    det(0);
    rd(16'd0, 8'h11, 1, "sat_lo");
    rd(16'd0, 8'h00, 0, "cleared");
    sw(1);
    ms(300);
    sw(0);
    rd(16'd0, 8'h04, 1, "short");
    sw(1);
    ms(790);
    rd(16'd0, 8'h00, 0, "long_early");
    ms(20);
    rd(16'd0, 8'h08, 1, "long");
    ms(200);
    sw(0);
    rd(16'd0, 8'h00, 0, "long_release");
    q.push_back('{"rd_det", 16'd1, 8'h00, 1'b0});
    drive(1, 1, 1, 0, 1, 0, 16'd0);
    rd(16'd1, 8'h03, 1, "rd_det_after");
    drive(1, 1, 0, 0, 0, 1, 16'h0500);
    rd(16'd255, 8'h02, 1, "wr_det");
    sw(1);
    ms(500);
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    sw_lvl = 0;
    rd(16'd0, 8'h00, 0, "reset_mid");
    ms(500);
    rd(16'd0, 8'h00, 0, "no_long");
    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/encoder_position_tracker.md
# encoder_position_tracker

Downstream consumer of the rotary-encoder decode stage on the front panel. Converts per-state-change strobes (`click`, `clockwise`, `switch`) into a bounded, saturating 16-bit position value with optional speed-based acceleration. Classifies encoder push-switch activity into short and long presses. Presents position and sticky event flags to the CPU through read/write strobes and an interrupt line.

## Interface
- `TICK_DIV`, 100000: clk cycles per 1 ms tick (100 MHz clk).
- `POS_MIN`, 0: lower saturation limit, unsigned.
- `POS_MAX`, 255: upper saturation limit, unsigned; must satisfy `POS_MAX >= POS_MIN`.
- `FAST_MS`, 20: detent interval (ms) below which a step counts as fast.
- `STEP_FAST`, 4: step size for a fast detent.
- `LONG_MS`, 800: hold time (ms) for a long press.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `enc_state_change_stb`, input, 1: one-cycle strobe from the encoder decoder.
- `click`, input, 1: detent indicator, valid only with the strobe.
- `clockwise`, input, 1: rotation direction, valid only with the strobe.
- `switch`, input, 1: debounced switch level (1 = pressed), valid only with the strobe.
- `pos_rd_stb`, input, 1: CPU read strobe.
- `pos_wr_stb`, input, 1: CPU write strobe.
- `pos_wr_data`, input, 16: position value to load.
- `position`, output, 16: current position.
- `event_reg`, output, 8: flag snapshot, captured on `pos_rd_stb`.
- `irq`, output, 1: high while any of flag bits [3:0] are set.

## Operation
- **Detent.** A detent is `enc_state_change_stb && click`.
  - Step size: `STEP_FAST` if the interval counter is below `FAST_MS`, otherwise 1.
  - Direction: add the step when `clockwise` = 1, subtract it when 0.
  - Result saturates to [`POS_MIN`, `POS_MAX`]. Arithmetic is done at 17 bits so no wrap-around is possible.
- **Interval counter.** 8 bits, counts ms ticks, saturates at 255, clears on every detent. Reset value is 255, so the first detent after reset is always slow.
- **Switch tracking.** A latched switch level updates only on a strobe. Switch FSM:
  - `SW_IDLE` to `SW_PRESSED` when the latched level goes 0→1. The hold counter clears.
  - `SW_PRESSED` to `SW_IDLE` on release with hold below `LONG_MS`; sets `SHORT`.
  - `SW_PRESSED` to `SW_LONG` when hold reaches `LONG_MS`; sets `LONG` immediately.
  - `SW_LONG` to `SW_IDLE` on release; no further flag is set.
- **Flags.** All bits are sticky:
  - [0] `MOVED`: a detent occurred.
  - [1] `DIR`: direction of the last detent (not cleared by a read).
  - [2] `SHORT`.
  - [3] `LONG`.
  - [4] `LIMIT`: a detent was clipped by saturation.
  - [5] `OVF`: a detent occurred while `MOVED` was already set.
  - [7:6]: always 0.
- **CPU read.** On `pos_rd_stb`, `event_reg` captures the flags and bits [0],[2],[3],[4],[5] clear. A flag event in the same cycle wins: the bit stays set, and the captured value shows its pre-event state.
- **CPU write.** On `pos_wr_stb`, position loads `pos_wr_data` clamped to the limits. A detent in the same cycle is discarded and no flags update. A write does not clear flags.
- **Reset values.**
  - `position` = `POS_MIN`; `event_reg` = 0; `irq` = 0.
  - Flags = 0; FSM = `SW_IDLE`; latched switch = 0.
  - Tick prescaler = 0; hold counter = 0.
  - Reset mid-press returns the FSM to idle; a switch still held afterwards needs a fresh 0→1 strobe.

## Timing
- `position` and flags update on the clock edge that samples the strobe, so they are visible one cycle after the strobe.
- `irq` is registered and rises one cycle after its flag.
- `event_reg` is valid the cycle after `pos_rd_stb`.
- The ms tick is a one-cycle pulse every `TICK_DIV` clocks. The hold counter (10 bits, saturating) advances only in `SW_PRESSED`.
- `LONG` asserts within one tick of `LONG_MS` ms elapsing after the press strobe.
- Back-to-back strobes on consecutive cycles are all processed; there is no dead time.

## Configuration
- `ENC_ACCEL_EN` defined: interval counter and fast-step logic are compiled in, as described above.
- `ENC_ACCEL_EN` undefined: every detent steps by 1, the interval counter is removed, and the `FAST_MS` and `STEP_FAST` parameters are ignored.

## Test plan
- **Slow rotation.** Reset, then 3 clockwise detents spaced 50 ms apart → `position` = 3, flags = 0x03, `irq` = 1. Read → `event_reg` = 0x03 and flags = 0x02.
- **Acceleration** (`ENC_ACCEL_EN` defined). Detents spaced 5 ms apart from `position` 100, with the first detent more than 20 ms after reset → 101, 105, 109. With the macro undefined → 101, 102, 103.
- **Saturation.** Write 254, then 2 fast clockwise detents → `position` = 255 with `LIMIT` and `OVF` set. Counter-clockwise detent from 0 → stays 0, `LIMIT` set.
- **Short vs long press.** Press strobe, release after 300 ms → `SHORT` only. Press, hold 1 s → `LONG` at about 800 ms; release → no `SHORT`.
- **Collisions.** `pos_rd_stb` coincident with a detent → `MOVED` remains set. `pos_wr_stb` (0x0500) coincident with a detent → `position` = 255 and flags unchanged.
- **Reset mid-press.** Assert `reset` during `SW_PRESSED` at 500 ms → all outputs return to reset values and no `LONG` follows.
